// File: rtl/uart_configurable.sv
// uart_configurable: one fractional baud/oversample tick generator shared by an
// oversampled RX path (mid-bit majority vote, false-start rejection, frame and
// parity flags) and a TX path. 5..8 data bits, none/odd/even parity, 1 or 2 stop bits.
module uart_configurable #(
  parameter int unsigned CLK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE     = 1000000,
  parameter int unsigned OVERSAMPLING  = 8,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned ACC_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic       tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);

  // Rounded accumulator increment: BAUD * OS * 2^ACC_WIDTH / CLK.
  localparam longint unsigned IncNum =
      64'(BAUD_RATE) * 64'(OVERSAMPLING) * (64'd1 << ACC_WIDTH);
  localparam longint unsigned IncRnd =
      (IncNum + 64'(CLK_FREQUENCY) / 64'd2) / 64'(CLK_FREQUENCY);
  localparam logic [ACC_WIDTH:0] Inc = IncRnd[ACC_WIDTH:0];

  localparam logic [3:0] OsLast   = 4'(OVERSAMPLING - 1);
  localparam logic [3:0] VoteLo   = 4'(OVERSAMPLING / 2 - 1);
  localparam logic [3:0] VoteMid  = 4'(OVERSAMPLING / 2);
  localparam logic [3:0] VoteHi   = 4'(OVERSAMPLING / 2 + 1);
  localparam logic [2:0] DataLast = 3'(DATA_BITS - 1);
  localparam logic [7:0] DataMask = 8'((32'd1 << DATA_BITS) - 32'd1);
  localparam logic       HasPar   = (PARITY != 0);
  localparam logic       OddPar   = (PARITY == 1);
  localparam logic       TwoStop  = (STOP_BITS == 2);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

  // ---------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 os_tick_q;

  assign acc_sum = {1'b0, acc_q} + Inc;

  // Free-running accumulator; the carry out becomes a one-clk oversample tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      os_tick_q <= 1'b0;
    end else begin
      acc_q     <= acc_sum[ACC_WIDTH-1:0];
      os_tick_q <= acc_sum[ACC_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic       rx_meta_q, rx_sync_q;
  rx_state_e  rx_state_q;
  logic [3:0] rx_cnt_q;
  logic [1:0] rx_ones_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic       rx_par_q;
  logic [7:0] rx_data_q;
  logic       rx_ready_q, rx_frame_err_q, rx_parity_err_q;
  logic       rx_vote, rx_last, rx_maj, rx_par_err;

  // Two-flop synchroniser, idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Vote point, end-of-bit and majority of the three mid-bit samples.
  always_comb begin
    rx_vote    = (rx_cnt_q == VoteHi);
    rx_last    = (rx_cnt_q == OsLast);
    // Two earlier samples are in rx_ones_q; the third is the current one.
    rx_maj     = (rx_ones_q == 2'd2) | ((rx_ones_q == 2'd1) & rx_sync_q);
    rx_par_err = HasPar & (^rx_shift_q ^ rx_par_q ^ OddPar);
  end

  // RX frame FSM with registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q      <= RxIdle;
      rx_cnt_q        <= '0;
      rx_ones_q       <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_par_q        <= 1'b0;
      rx_data_q       <= '0;
      rx_ready_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_parity_err_q <= 1'b0;
    end else begin
      rx_ready_q <= 1'b0;
      if (os_tick_q) begin
        if (rx_state_q != RxIdle) begin
          rx_cnt_q <= rx_last ? 4'd0 : rx_cnt_q + 4'd1;
          if (rx_cnt_q == VoteLo)  rx_ones_q <= {1'b0, rx_sync_q};
          if (rx_cnt_q == VoteMid) rx_ones_q <= rx_ones_q + {1'b0, rx_sync_q};
        end
        unique case (rx_state_q)
          RxIdle: begin
            if (!rx_sync_q) begin
              rx_state_q <= RxStart;
              rx_cnt_q   <= '0;
              rx_shift_q <= '0;
            end
          end
          RxStart: begin
            if (rx_vote && rx_maj) begin
              rx_state_q <= RxIdle;  // glitch, not a real start bit
            end else if (rx_last) begin
              rx_state_q <= RxData;
              rx_bit_q   <= '0;
            end
          end
          RxData: begin
            if (rx_vote) rx_shift_q[rx_bit_q] <= rx_maj;
            if (rx_last) begin
              rx_bit_q <= rx_bit_q + 3'd1;
              if (rx_bit_q == DataLast) rx_state_q <= HasPar ? RxParity : RxStop;
            end
          end
          RxParity: begin
            if (rx_vote) rx_par_q <= rx_maj;
            if (rx_last) rx_state_q <= RxStop;
          end
          RxStop: begin
            // Finish at the vote point so a following start edge in the
            // back half of the stop bit is not missed.
            if (rx_vote) begin
              rx_data_q       <= rx_shift_q;
              rx_frame_err_q  <= ~rx_maj;
              rx_parity_err_q <= rx_par_err;
              rx_ready_q      <= 1'b1;
              rx_state_q      <= RxIdle;
            end
          end
          default: rx_state_q <= RxIdle;
        endcase
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_ready      = rx_ready_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_parity_err = rx_parity_err_q;

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  tx_state_e  tx_state_q;
  logic       tx_q, tx_busy_q, tx_pend_q, tx_par_q, tx_stop_q;
  logic [3:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  logic [7:0] tx_masked;

  assign tx_masked = tx_data & DataMask;

  // TX frame FSM; tx is a register so async reset forces the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_pend_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_q  <= 1'b1;
        tx_pend_q  <= 1'b1;
        tx_shift_q <= tx_masked;
        tx_par_q   <= ^tx_masked ^ OddPar;
        tx_state_q <= TxStart;
      end
    end else if (os_tick_q) begin
      if (tx_pend_q) begin
        // Start bit begins on the first tick after acceptance.
        tx_q      <= 1'b0;
        tx_pend_q <= 1'b0;
        tx_cnt_q  <= '0;
      end else if (tx_cnt_q != OsLast) begin
        tx_cnt_q <= tx_cnt_q + 4'd1;
      end else begin
        tx_cnt_q <= '0;
        unique case (tx_state_q)
          TxStart: begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= '0;
            tx_state_q <= TxData;
          end
          TxData: begin
            if (tx_bit_q == DataLast) begin
              tx_stop_q <= 1'b0;
              if (HasPar) begin
                tx_q       <= tx_par_q;
                tx_state_q <= TxParity;
              end else begin
                tx_q       <= 1'b1;
                tx_state_q <= TxStop;
              end
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
          TxParity: begin
            tx_q       <= 1'b1;
            tx_stop_q  <= 1'b0;
            tx_state_q <= TxStop;
          end
          TxStop: begin
            if (TwoStop && !tx_stop_q) begin
              tx_stop_q <= 1'b1;
            end else begin
              tx_busy_q  <= 1'b0;
              tx_state_q <= TxIdle;
            end
          end
          default: begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_state_q <= TxIdle;
          end
        endcase
      end
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_configurable.sv
// tb_uart_configurable: three UART instances (8N1/OS8, 7E2/OS8 in loopback,
// 8O1/OS16), all with a 64-clk bit period. Directed table plus random frames.
module tb_uart_configurable;

  localparam int unsigned ClkHz = 100000000;
  localparam int unsigned Baud  = 1562500;
  localparam int          BitClk = 64;

  logic       clk, reset;
  logic       rx_a, rx_c;
  logic [7:0] rxd [3];
  logic       rdy [3];
  logic       fe  [3];
  logic       pe  [3];
  logic       txl [3];
  logic       txs [3];
  logic       txb [3];
  logic [7:0] txd [3];

  int         rdy_cnt  [3] = '{0, 0, 0};
  logic [7:0] got_data [3];
  logic       got_fe   [3];
  logic       got_pe   [3];

  int n_checks, n_pass;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t tbl [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_configurable #(
    .CLK_FREQUENCY(ClkHz), .BAUD_RATE(Baud), .OVERSAMPLING(8), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .ACC_WIDTH(16)
  ) u_8n1 (
    .clk(clk), .reset(reset), .rx(rx_a), .rx_data(rxd[0]), .rx_ready(rdy[0]),
    .rx_frame_err(fe[0]), .rx_parity_err(pe[0]), .tx(txl[0]), .tx_start(txs[0]),
    .tx_data(txd[0]), .tx_busy(txb[0])
  );

  uart_configurable #(
    .CLK_FREQUENCY(ClkHz), .BAUD_RATE(Baud), .OVERSAMPLING(8), .DATA_BITS(7),
    .PARITY(2), .STOP_BITS(2), .ACC_WIDTH(16)
  ) u_7e2 (
    .clk(clk), .reset(reset), .rx(txl[1]), .rx_data(rxd[1]), .rx_ready(rdy[1]),
    .rx_frame_err(fe[1]), .rx_parity_err(pe[1]), .tx(txl[1]), .tx_start(txs[1]),
    .tx_data(txd[1]), .tx_busy(txb[1])
  );

  uart_configurable #(
    .CLK_FREQUENCY(ClkHz), .BAUD_RATE(Baud), .OVERSAMPLING(16), .DATA_BITS(8),
    .PARITY(1), .STOP_BITS(1), .ACC_WIDTH(16)
  ) u_8o1 (
    .clk(clk), .reset(reset), .rx(rx_c), .rx_data(rxd[2]), .rx_ready(rdy[2]),
    .rx_frame_err(fe[2]), .rx_parity_err(pe[2]), .tx(txl[2]), .tx_start(txs[2]),
    .tx_data(txd[2]), .tx_busy(txb[2])
  );

  // Record every rx_ready pulse with the result it delivered.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] === 1'b1) begin
        rdy_cnt[i]  <= rdy_cnt[i] + 1;
        got_data[i] <= rxd[i];
        got_fe[i]   <= fe[i];
        got_pe[i]   <= pe[i];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Reference serial frame, LSB first: start, data, optional parity, stops.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int nd,
                                              input int par, input int ns);
    logic [15:0] f;
    int n, ones;
    f = '0;
    n = 1;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      f[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par != 0) begin
      f[n] = (par == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  // Drive a frame onto rx_a (sel 0) or rx_c (otherwise), one bit per 64 clk.
  task automatic drive_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_a = bits[i];
      else rx_c = bits[i];
      repeat (BitClk) @(negedge clk);
    end
    if (sel == 0) rx_a = 1'b1;
    else rx_c = 1'b1;
  endtask

  // Send one byte and sample the line at the centre of every bit.
  task automatic tx_frame(input int sel, input logic [7:0] d, input int nbits,
                          output logic [15:0] bits, output int busy_len,
                          output int low_len, output bit done);
    int fall, rise, j;
    fall = -1;
    rise = -1;
    j = 0;
    bits = '0;
    busy_len = 0;
    done = 1'b0;
    txd[sel] = d;
    txs[sel] = 1'b1;
    @(negedge clk);
    txs[sel] = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (txb[sel]) busy_len++;
      if (fall < 0 && !txl[sel]) fall = k;
      else if (fall >= 0 && rise < 0 && txl[sel]) rise = k;
      if (fall >= 0 && j < nbits && k - fall == 32 + BitClk * j) begin
        bits[j] = txl[sel];
        j++;
      end
      if (!txb[sel]) begin
        done = (j == nbits);
        break;
      end
      @(negedge clk);
    end
    low_len = (rise > fall) ? rise - fall : 0;
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  r, r2;
    logic        pb, sb;
    int          blen, llen, c0, ones;
    bit          done;

    n_checks = 0;
    n_pass   = 0;
    tbl[0] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hA7, 1'b0, 1'b1, 8'hA7, 1'b0, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[7] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};

    reset = 1'b1;
    rx_a  = 1'b1;
    rx_c  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txs[i] = 1'b0;
      txd[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rxd[0]), 32'h0);
    check("rst_rx_ready", 32'(rdy[0]), 32'h0);
    check("rst_frame_err", 32'(fe[0]), 32'h0);
    check("rst_parity_err", 32'(pe[0]), 32'h0);
    check("rst_tx", 32'(txl[0]), 32'h1);
    check("rst_tx_busy", 32'(txb[0]), 32'h0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_tx", 32'(txl[0]), 32'h1);

    // 8N1 transmit of A5: exact bit pattern, start-bit width and busy length.
    tx_frame(0, 8'hA5, 10, bits, blen, llen, done);
    check("a5_done", 32'(done), 32'h1);
    check("a5_bits", 32'(bits), 32'h34A);
    check("a5_start_width", 32'(llen), 32'(BitClk));
    check_range("a5_busy_len", blen, 632, 648);

    // 7E2 loopback of C3: 11-bit frame, 7 data bits received.
    c0 = rdy_cnt[1];
    tx_frame(1, 8'hC3, 11, bits, blen, llen, done);
    repeat (BitClk) @(negedge clk);
    check("c3_done", 32'(done), 32'h1);
    check("c3_bits", 32'(bits), 32'h786);
    check_range("c3_busy_len", blen, 704, 712);
    check("c3_ready_count", 32'(rdy_cnt[1] - c0), 32'h1);
    check("c3_rx_data", 32'(got_data[1]), 32'h43);
    check("c3_parity_err", 32'(got_pe[1]), 32'h0);
    check("c3_frame_err", 32'(got_fe[1]), 32'h0);

    // 8O1 table: parity and framing flags, including flag clearing.
    for (int i = 0; i < 8; i++) begin
      c0 = rdy_cnt[2];
      drive_bits(1, {5'b0, tbl[i].stop, tbl[i].pbit, tbl[i].data, 1'b0}, 11);
      repeat (2 * BitClk) @(negedge clk);
      check($sformatf("tbl%0d_count", i), 32'(rdy_cnt[2] - c0), 32'h1);
      check($sformatf("tbl%0d_data", i), 32'(got_data[2]), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_parity_err", i), 32'(got_pe[2]), 32'(tbl[i].exp_pe));
      check($sformatf("tbl%0d_frame_err", i), 32'(got_fe[2]), 32'(tbl[i].exp_fe));
    end

    // 8N1 frame error: stop bit forced low, exactly one pulse.
    c0 = rdy_cnt[0];
    drive_bits(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
    repeat (3 * BitClk) @(negedge clk);
    check("ferr_count", 32'(rdy_cnt[0] - c0), 32'h1);
    check("ferr_data", 32'(got_data[0]), 32'h55);
    check("ferr_flag", 32'(got_fe[0]), 32'h1);

    // 16-clk glitch is rejected; the next valid frame still arrives.
    c0 = rdy_cnt[0];
    rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * BitClk) @(negedge clk);
    check("glitch_no_ready", 32'(rdy_cnt[0] - c0), 32'h0);
    drive_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (2 * BitClk) @(negedge clk);
    check("glitch_next_count", 32'(rdy_cnt[0] - c0), 32'h1);
    check("glitch_next_data", 32'(got_data[0]), 32'h3C);
    check("glitch_next_ferr", 32'(got_fe[0]), 32'h0);

    // Reset during data bit 4 forces tx high and busy low without a clock.
    txd[0] = 8'h0F;
    txs[0] = 1'b1;
    @(negedge clk);
    txs[0] = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (!txl[0]) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_tx_started", 32'(done), 32'h1);
    repeat (5 * BitClk + 20) @(negedge clk);
    check("rst_mid_bit4_low", 32'(txl[0]), 32'h0);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_tx_high", 32'(txl[0]), 32'h1);
    check("rst_mid_busy_low", 32'(txb[0]), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    tx_frame(0, 8'hFF, 10, bits, blen, llen, done);
    check("ff_done", 32'(done), 32'h1);
    check("ff_bits", 32'(bits), 32'h3FE);
    check_range("ff_busy_len", blen, 632, 648);

    // Random 8N1: RX and TX active at the same time.
    for (int i = 0; i < 6; i++) begin
      r  = 8'($urandom);
      r2 = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      c0 = rdy_cnt[0];
      fork
        drive_bits(0, {6'b0, sb, r, 1'b0}, 10);
        tx_frame(0, r2, 10, bits, blen, llen, done);
      join
      repeat (2 * BitClk) @(negedge clk);
      check($sformatf("rnd_a%0d_count", i), 32'(rdy_cnt[0] - c0), 32'h1);
      check($sformatf("rnd_a%0d_data", i), 32'(got_data[0]), 32'(r));
      check($sformatf("rnd_a%0d_ferr", i), 32'(got_fe[0]), 32'(!sb));
      check($sformatf("rnd_a%0d_perr", i), 32'(got_pe[0]), 32'h0);
      check($sformatf("rnd_a%0d_tx", i), 32'(bits), 32'(model_frame(r2, 8, 0, 1)));
    end

    // Random 7E2 loopback.
    for (int i = 0; i < 6; i++) begin
      r  = 8'($urandom);
      c0 = rdy_cnt[1];
      tx_frame(1, r, 11, bits, blen, llen, done);
      repeat (BitClk) @(negedge clk);
      check($sformatf("rnd_b%0d_tx", i), 32'(bits), 32'(model_frame(r, 7, 2, 2)));
      check($sformatf("rnd_b%0d_count", i), 32'(rdy_cnt[1] - c0), 32'h1);
      check($sformatf("rnd_b%0d_data", i), 32'(got_data[1]), 32'(r & 8'h7F));
      check($sformatf("rnd_b%0d_perr", i), 32'(got_pe[1]), 32'h0);
    end

    // Random 8O1 with arbitrary parity and stop bits.
    for (int i = 0; i < 8; i++) begin
      r  = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      ones = $countones(r) + int'(pb);
      c0 = rdy_cnt[2];
      drive_bits(1, {5'b0, sb, pb, r, 1'b0}, 11);
      repeat (2 * BitClk) @(negedge clk);
      check($sformatf("rnd_c%0d_count", i), 32'(rdy_cnt[2] - c0), 32'h1);
      check($sformatf("rnd_c%0d_data", i), 32'(got_data[2]), 32'(r));
      check($sformatf("rnd_c%0d_perr", i), 32'(got_pe[2]), 32'((ones % 2) == 0));
      check($sformatf("rnd_c%0d_ferr", i), 32'(got_fe[2]), 32'(!sb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_configurable.md
Name: uart_configurable

Overview:
Parametrised UART successor for the lab designs. It provides one shared fractional baud/oversample generator plus an RX and a TX path. Both paths support 5–8 data bits, optional odd/even parity, 1 or 2 stop bits and 8x/16x oversampling. The RX path adds mid-bit majority voting, false-start rejection and framing/parity error flags. It drops in wherever the fixed 8N1 UART is used today, in front of command decoders and display/LED controllers.

Parameters:
CLK_FREQUENCY, 100000000, system clock in Hz
BAUD_RATE, 1000000, line bit rate in Hz
OVERSAMPLING, 8, oversample ticks per bit; legal values 8 or 16 only
DATA_BITS, 8, payload bits per frame, 5..8, sent and received LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2 stop bits; TX emits all of them, RX checks only the first
ACC_WIDTH, 16, width of the fractional baud accumulator

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
rx  input  1  serial input, idle high, asynchronous to clk
rx_data  output  8  last received payload, bits above DATA_BITS-1 are zero
rx_ready  output  1  one-cycle pulse: new frame present on rx_data and flags
rx_frame_err  output  1  first stop bit of last frame sampled 0
rx_parity_err  output  1  parity mismatch on last frame; always 0 when PARITY=0
tx  output  1  serial output, idle high
tx_start  input  1  request to send tx_data
tx_data  input  8  payload; only bits DATA_BITS-1..0 transmitted
tx_busy  output  1  TX frame in progress

Behaviour:
- Reset (async, active-high): rx_data=0, rx_ready=0, rx_frame_err=0, rx_parity_err=0, tx=1, tx_busy=0; RX and TX FSMs go to IDLE, accumulator=0, rx synchroniser flops=1. Asserting reset mid-frame aborts the frame immediately; tx returns to 1 without waiting for a clock.
- Tick generator: free-running ACC_WIDTH+1-bit accumulator, INC = round(BAUD_RATE*OVERSAMPLING*2^ACC_WIDTH/CLK_FREQUENCY). os_tick = carry out, one clk wide. A bit period is OVERSAMPLING os_ticks.
- RX input passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- IDLE: the first os_tick with synced rx=0 enters START and clears the tick counter to 0.
- In every RX state, the bit value is the majority of samples at tick counts OS/2-1, OS/2 and OS/2+1. The state advances when the counter reaches OS-1.
- START: majority=1 means a false start; return to IDLE with no pulse and no flag change.
- DATA: shift LSB first for DATA_BITS bits.
- PARITY: compare against the XOR of the data bits (odd: total ones incl. parity is odd; even: even).
- STOP: evaluated at the vote point, not at the end of the bit. rx_data, rx_frame_err and rx_parity_err update in the same clk that rx_ready pulses, then the FSM returns to IDLE. A new start edge is therefore accepted within the back half of the stop bit. Outputs hold until the next completed frame.
- A frame is delivered even when it has errors; the flags describe it.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
- Accept: tx_start=1 while tx_busy=0 latches tx_data, and tx_busy=1 on the next clk.
- tx_start while tx_busy=1 is ignored; there is no queuing.
- After acceptance, tx drops to 0 at the next os_tick. Each bit then lasts exactly OVERSAMPLING os_ticks.
- tx_busy falls in the clk after the last stop bit completes. tx_start sampled in that same cycle is accepted, giving back-to-back frames.
- RX and TX are independent; simultaneous activity is required to work, including external loopback.

Test Plan:
- Params CLK=100000000, BAUD=1562500, OS=8, 8N1 (os_tick every 8 clk, bit = 64 clk). Pulse tx_start with tx_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each 64±8 clk. tx_busy high for 640±8 clk.
- Loop tx to rx with 7E2 (DATA_BITS=7, PARITY=2, STOP_BITS=2), send 8'hC3 -> rx_ready pulse; rx_data=8'h43, rx_parity_err=0, rx_frame_err=0. TX frame is 11 bits.
- Drive an 8O1 frame with 8'h00 and a wrong parity bit=0 -> rx_parity_err=1, rx_data=8'h00. Next good frame clears the flag.
- Drive 8N1 8'h55 with stop bit forced 0 -> rx_frame_err=1, rx_ready pulses once.
- 16-clk low glitch on idle rx -> no rx_ready; the next valid frame 8'h3C is received correctly.
- Assert reset for 3 clk mid-TX data bit 4 -> tx=1 and tx_busy=0 immediately. A fresh tx_start 8'hFF sends a complete correct frame.
